cmp_arbiter: RTL
================

# cmp_arbiter

Round-robin scheduler that shares one unsigned magnitude comparator among NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants one requester per cycle and performs the greater/less/equal compare. The result is registered, tagged with the winning requester's index and returned over a single valid/ready result port. It sits between the comparator datapath and its clients, so several client blocks can issue comparisons without duplicating comparators.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 4, operand width in bits; compare is unsigned
- IDW, $clog2(NREQ), width of the requester index
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i presents an operand pair
- req_ready  out  NREQ  bit i: requester i is granted this cycle; one-hot or zero
- req_a  in  NREQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B of requester i at bits [i*WIDTH +: WIDTH]
- res_valid  out  1  result register holds an undelivered result
- res_ready  in  1  consumer accepts the result
- res_id  out  IDW  index of the requester that produced the result
- res_gt, res_lt, res_eq  out  1 each  A>B, A<B, A==B; exactly one is high while res_valid=1

## Operation
- Result slot is a single-entry register with states EMPTY (res_valid=0) and FULL (res_valid=1).
- The slot is free when it is EMPTY, or when it is FULL and res_ready=1 in the same cycle (drain-and-refill).
- Arbitration (combinational):
  - Only runs when the slot is free.
  - Scan starts at the round-robin pointer ptr and proceeds ptr, ptr+1, … mod NREQ.
  - The first i with req_valid[i]=1 wins, and req_ready[i] is asserted.
  - All other req_ready bits are 0.
  - When the slot is not free, req_ready is all-zero.
- Transfer:
  - Occurs when req_valid[i] & req_ready[i].
  - On that edge, the slot captures res_id=i and gt/lt/eq from an unsigned compare of req_a[i] and req_b[i], and res_valid is set.
  - ptr is set to (i+1) mod NREQ; it wraps from NREQ-1 to 0.
- Drain:
  - res_valid & res_ready with no transfer: slot goes to EMPTY and res_valid clears.
  - res_id and the gt/lt/eq fields hold their last value.
- ptr is unchanged in any cycle without a transfer.
- Requester rules:
  - Once asserted, req_valid and the operands stay stable until accepted.
  - req_valid must not depend on req_ready.
  - The block does not check these rules.
- Consumer rule: res_valid and the result fields stay stable until res_ready.
- Reset:
  - Values: res_valid=0, res_id=0, res_gt=0, res_lt=0, res_eq=0, ptr=0, req_ready all-zero.
  - Reset asserted mid-operation discards any pending result immediately, without waiting for a clock edge.
  - No request is granted while rst=1.

## Timing
- Latency: the result appears the cycle after the request is accepted (1 clock).
- Throughput: one comparison per cycle sustained when res_ready stays high.
- Stall: while the slot is FULL and res_ready=0, no grant is made and requesters wait.
- Fairness: a continuously valid requester is granted within NREQ grants.
- First cycle after reset deassertion: the highest-priority requester is index 0.
- req_ready is combinational from req_valid, ptr, res_valid and res_ready. No other combinational path exists.

## Test plan
- Single request, NREQ=4, WIDTH=4: req_valid=0001, A0=9, B0=3, res_ready=1.
  - req_ready=0001 in cycle 0.
  - Next cycle: res_valid=1, res_id=0, res_gt=1, res_lt=0, res_eq=0.
- Round-robin wrap: all four requesters held valid with operands (1,2), (5,5), (7,0), (0,0), res_ready=1.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Results in order: lt, eq, gt, eq, lt.
  - One result per cycle.
- Backpressure: hold res_ready=0 after the first result.
  - req_ready stays 0000.
  - res_valid, res_id and the flags stay stable.
  - Raising res_ready drains the slot and grants the next requester in the same cycle.
- Priority after grant: ptr=2, req_valid=1011.
  - Requester 3 wins first, then 0, then 1.
- Equality and extremes:
  - A=F, B=F gives eq.
  - A=0, B=F gives lt.
  - A=F, B=0 gives gt.
  - Only one flag is high in each case.
- Reset mid-operation: assert rst while res_valid=1 and no edge has occurred.
  - res_valid, res_id and all flags go to 0 immediately.
  - After release, requester 0 has priority.

Source files
------------

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among NREQ requesters.
// Each accepted operand pair is compared and the result is held in a single-entry slot, tagged with the requester index.
module cmp_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [IDW-1:0]          res_id,
  output logic                    res_gt,
  output logic                    res_lt,
  output logic                    res_eq
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic             slot_free;
  logic             found;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   win_id;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] op_a, op_b;

  // Scan from ptr upward (mod NREQ); the first valid requester wins while the slot can accept.
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    idx       = '0;
    win_id    = '0;
    slot_free = (state_q == EMPTY) || res_ready;
    if (slot_free && !rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = IDW'((32'(ptr_q) + k) % NREQ);
        if (!found && req_valid[idx]) begin
          found  = 1'b1;
          win_id = idx;
        end
      end
    end
    if (found) grant[win_id] = 1'b1;
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        op_a = req_a[k*WIDTH +: WIDTH];
        op_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Slot next-state: refill on transfer, else drain; fields hold on drain.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    if (found) begin
      state_d = FULL;
      ptr_d   = IDW'((32'(win_id) + 32'd1) % NREQ);
      id_d    = win_id;
      gt_d    = op_a > op_b;
      lt_d    = op_a < op_b;
      eq_d    = op_a == op_b;
    end else if (state_q == FULL && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign req_ready = grant;
  assign res_valid = (state_q == FULL);
  assign res_id    = id_q;
  assign res_gt    = gt_q;
  assign res_lt    = lt_q;
  assign res_eq    = eq_q;

endmodule
